// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator and the display path.
// The generator side is the master; run is its only input.
interface vga_timing_if #(
    parameter int h_width = 10,
    parameter int v_width = 10
);
    logic               run;
    logic               pixel_tick;
    logic [h_width-1:0] h_count;
    logic [v_width-1:0] v_count;
    logic               hsync;
    logic               vsync;
    logic               visible;
    logic               line_end;
    logic               frame_end;

    modport master (
        input  run,
        output pixel_tick,
        output h_count,
        output v_count,
        output hsync,
        output vsync,
        output visible,
        output line_end,
        output frame_end
    );

    modport slave (
        output run,
        input  pixel_tick,
        input  h_count,
        input  v_count,
        input  hsync,
        input  vsync,
        input  visible,
        input  line_end,
        input  frame_end
    );
endinterface

// File: rtl/vga_timing.sv
// Raster timing generator: pixel-rate divider plus one region FSM and
// counter per axis, with sync, visible and wrap strobes decoded from them.
module vga_timing_axis #(
    parameter int active = 640,
    parameter int front  = 16,
    parameter int sync   = 96,
    parameter int back   = 48,
    parameter int width  = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    output logic [width-1:0] count,
    output logic             in_sync,
    output logic             in_active,
    output logic             at_last
);
    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } state_t;

    localparam int total = active + front + sync + back;

    localparam logic [width-1:0] end_active = width'(active - 1);
    localparam logic [width-1:0] end_front  = width'(active + front - 1);
    localparam logic [width-1:0] end_sync   = width'(active + front + sync - 1);
    localparam logic [width-1:0] end_back   = width'(total - 1);

    state_t             state;
    state_t             state_next;
    logic [width-1:0]   cnt;
    logic [width-1:0]   cnt_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ACTIVE;
            cnt   <= '0;
        end else if (!run) begin
            state <= ACTIVE;
            cnt   <= '0;
        end else if (step) begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Empty porch/sync regions are skipped by jumping to the next non-empty one.
    always_comb begin
        state_next = state;
        cnt_next   = (cnt == end_back) ? '0 : cnt + width'(1);
        unique case (state)
            ACTIVE: begin
                if (cnt == end_active) begin
                    if (front != 0)
                        state_next = FRONT;
                    else if (sync != 0)
                        state_next = SYNC;
                    else if (back != 0)
                        state_next = BACK;
                end
            end
            FRONT: begin
                if (cnt == end_front) begin
                    if (sync != 0)
                        state_next = SYNC;
                    else if (back != 0)
                        state_next = BACK;
                    else
                        state_next = ACTIVE;
                end
            end
            SYNC: begin
                if (cnt == end_sync) begin
                    if (back != 0)
                        state_next = BACK;
                    else
                        state_next = ACTIVE;
                end
            end
            BACK: begin
                if (cnt == end_back)
                    state_next = ACTIVE;
            end
        endcase
    end

    // While stopped, the registers may still hold a stale position for one
    // clock, so the outputs are forced to their reset view directly.
    assign count     = run ? cnt : '0;
    assign in_sync   = run && (state == SYNC);
    assign in_active = !run || (state == ACTIVE);
    assign at_last   = run && (cnt == end_back);
endmodule

module vga_timing #(
    parameter int h_active        = 640,
    parameter int h_front         = 16,
    parameter int h_sync          = 96,
    parameter int h_back          = 48,
    parameter int v_active        = 480,
    parameter int v_front         = 10,
    parameter int v_sync          = 2,
    parameter int v_back          = 33,
    parameter int h_width         = 10,
    parameter int v_width         = 10,
    parameter int clock_divide    = 2,
    parameter bit sync_active_low = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    vga_timing_if.master bus
);
    localparam int div_width = (clock_divide > 1) ? $clog2(clock_divide) : 1;

    localparam logic [div_width-1:0] div_last = div_width'(clock_divide - 1);

    logic [div_width-1:0] div;
    logic                 tick;
    logic                 h_sync_on;
    logic                 h_active_on;
    logic                 h_last;
    logic                 v_sync_on;
    logic                 v_active_on;
    logic                 v_last;
    logic                 line_end;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            div <= '0;
        else if (!bus.run || div == div_last)
            div <= '0;
        else
            div <= div + div_width'(1);
    end

    assign tick = bus.run ? (div == div_last) : (clock_divide == 1);

    vga_timing_axis #(
        .active (h_active),
        .front  (h_front),
        .sync   (h_sync),
        .back   (h_back),
        .width  (h_width)
    ) u_h (
        .clock     (clock),
        .reset     (reset),
        .run       (bus.run),
        .step      (tick),
        .count     (bus.h_count),
        .in_sync   (h_sync_on),
        .in_active (h_active_on),
        .at_last   (h_last)
    );

    vga_timing_axis #(
        .active (v_active),
        .front  (v_front),
        .sync   (v_sync),
        .back   (v_back),
        .width  (v_width)
    ) u_v (
        .clock     (clock),
        .reset     (reset),
        .run       (bus.run),
        .step      (line_end),
        .count     (bus.v_count),
        .in_sync   (v_sync_on),
        .in_active (v_active_on),
        .at_last   (v_last)
    );

    assign line_end       = tick && h_last;
    assign bus.line_end   = line_end;
    assign bus.frame_end  = line_end && v_last;
    assign bus.pixel_tick = tick;
    assign bus.hsync      = h_sync_on ^ sync_active_low;
    assign bus.vsync      = v_sync_on ^ sync_active_low;
    assign bus.visible    = h_active_on && v_active_on;
endmodule

// File: tb/tb_vga_timing.sv
// Randomized run/reset stimulus on three timing configurations, checked
// against an arithmetic raster model driven by elapsed clock count.
module tb_vga_timing;
    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        int cd, sal;
    } cfg_t;

    typedef struct {
        int tick, h, v, hs, vs, vis, le, fe;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n [3];
    cfg_t cfg [3];

    always #5 clock = ~clock;

    vga_timing_if #(.h_width(10), .v_width(10)) b0 ();
    vga_timing_if #(.h_width(3),  .v_width(3))  b1 ();
    vga_timing_if #(.h_width(3),  .v_width(3))  b2 ();

    vga_timing #(.clock_divide(2)) u0 (
        .clock (clock),
        .reset (reset),
        .bus   (b0)
    );

    vga_timing #(
        .h_active(4), .h_front(1), .h_sync(2), .h_back(1),
        .v_active(3), .v_front(1), .v_sync(1), .v_back(1),
        .h_width(3), .v_width(3), .clock_divide(1), .sync_active_low(1'b0)
    ) u1 (
        .clock (clock),
        .reset (reset),
        .bus   (b1)
    );

    vga_timing #(
        .h_active(4), .h_front(0), .h_sync(2), .h_back(1),
        .v_active(3), .v_front(0), .v_sync(1), .v_back(1),
        .h_width(3), .v_width(3), .clock_divide(3), .sync_active_low(1'b1)
    ) u2 (
        .clock (clock),
        .reset (reset),
        .bus   (b2)
    );

    logic        run_now [3];
    logic [31:0] o_tick [3], o_h [3], o_v [3], o_hs [3];
    logic [31:0] o_vs [3], o_vis [3], o_le [3], o_fe [3];

    assign run_now[0] = b0.run;
    assign run_now[1] = b1.run;
    assign run_now[2] = b2.run;
    assign o_tick[0] = 32'(b0.pixel_tick);
    assign o_tick[1] = 32'(b1.pixel_tick);
    assign o_tick[2] = 32'(b2.pixel_tick);
    assign o_h[0]    = 32'(b0.h_count);
    assign o_h[1]    = 32'(b1.h_count);
    assign o_h[2]    = 32'(b2.h_count);
    assign o_v[0]    = 32'(b0.v_count);
    assign o_v[1]    = 32'(b1.v_count);
    assign o_v[2]    = 32'(b2.v_count);
    assign o_hs[0]   = 32'(b0.hsync);
    assign o_hs[1]   = 32'(b1.hsync);
    assign o_hs[2]   = 32'(b2.hsync);
    assign o_vs[0]   = 32'(b0.vsync);
    assign o_vs[1]   = 32'(b1.vsync);
    assign o_vs[2]   = 32'(b2.vsync);
    assign o_vis[0]  = 32'(b0.visible);
    assign o_vis[1]  = 32'(b1.visible);
    assign o_vis[2]  = 32'(b2.visible);
    assign o_le[0]   = 32'(b0.line_end);
    assign o_le[1]   = 32'(b1.line_end);
    assign o_le[2]   = 32'(b2.line_end);
    assign o_fe[0]   = 32'(b0.frame_end);
    assign o_fe[1]   = 32'(b1.frame_end);
    assign o_fe[2]   = 32'(b2.frame_end);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, want, $time);
        end
    endtask

    // Raster position from the number of running clocks since restart.
    function automatic exp_t model(input int clk_n, input cfg_t c);
        exp_t e;
        int ht, vt, p, hs0, vs0;
        ht    = c.ha + c.hf + c.hs + c.hb;
        vt    = c.va + c.vf + c.vs + c.vb;
        p     = clk_n / c.cd;
        e.h   = p % ht;
        e.v   = (p / ht) % vt;
        e.tick = int'((clk_n % c.cd) == c.cd - 1);
        hs0   = c.ha + c.hf;
        vs0   = c.va + c.vf;
        e.hs  = int'(e.h >= hs0 && e.h < hs0 + c.hs) ^ c.sal;
        e.vs  = int'(e.v >= vs0 && e.v < vs0 + c.vs) ^ c.sal;
        e.vis = int'(e.h < c.ha && e.v < c.va);
        e.le  = int'(e.tick == 1 && e.h == ht - 1);
        e.fe  = int'(e.le == 1 && e.v == vt - 1);
        return e;
    endfunction

    task automatic check_dut(input int d);
        exp_t e;
        e = model((reset && run_now[d]) ? n[d] : 0, cfg[d]);
        chk($sformatf("u%0d.pixel_tick", d), o_tick[d], 32'(e.tick));
        chk($sformatf("u%0d.h_count", d),    o_h[d],    32'(e.h));
        chk($sformatf("u%0d.v_count", d),    o_v[d],    32'(e.v));
        chk($sformatf("u%0d.hsync", d),      o_hs[d],   32'(e.hs));
        chk($sformatf("u%0d.vsync", d),      o_vs[d],   32'(e.vs));
        chk($sformatf("u%0d.visible", d),    o_vis[d],  32'(e.vis));
        chk($sformatf("u%0d.line_end", d),   o_le[d],   32'(e.le));
        chk($sformatf("u%0d.frame_end", d),  o_fe[d],   32'(e.fe));
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++)
            check_dut(d);
    endtask

    task automatic set_run(input int d, input logic val);
        case (d)
            0: b0.run = val;
            1: b1.run = val;
            default: b2.run = val;
        endcase
    endtask

    task automatic step();
        @(posedge clock);
        for (int d = 0; d < 3; d++)
            n[d] = (reset && run_now[d]) ? n[d] + 1 : 0;
        @(negedge clock);
        check_all();
    endtask

    initial begin
        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1};
        cfg[1] = '{4, 1, 2, 1, 3, 1, 1, 1, 1, 0};
        cfg[2] = '{4, 0, 2, 1, 3, 0, 1, 1, 3, 1};
        for (int d = 0; d < 3; d++) begin
            n[d] = 0;
            set_run(d, 1'b1);
        end
        #1 reset = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        repeat (3300) step();
        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(1, 400)) step();
            case ($urandom_range(0, 2))
                0: begin
                    for (int d = 0; d < 3; d++)
                        if ($urandom_range(0, 1) == 1)
                            set_run(d, 1'b0);
                    #1 check_all();
                    repeat ($urandom_range(1, 4)) step();
                    for (int d = 0; d < 3; d++)
                        set_run(d, 1'b1);
                end
                1: begin
                    #($urandom_range(1, 3));
                    reset = 1'b0;
                    for (int d = 0; d < 3; d++)
                        n[d] = 0;
                    #1 check_all();
                    repeat ($urandom_range(1, 3)) step();
                    reset = 1'b1;
                end
                default: ;
            endcase
        end
        repeat (50) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
